// File: rtl/multi_channel_solar_monitor.sv
// multi_channel_solar_monitor
// Monitors N_CH panel strings sharing one temperature sensor. Each accepted
// snapshot is scanned one channel per cycle through a single shared
// multiplier and accumulated over 2^AVG_LOG2 snapshots. At the end of each
// window one averaged record per channel is streamed over valid/ready, with a
// running total-power sum (meaningful on the last record), per-channel
// under-power alarms and a shared over-temperature alarm.
//
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   sample_valid/sample_ready   snapshot handshake (ready only in IDLE)
//   voltage, current            packed per-channel words, ch k at [k*DATA_W +: DATA_W]
//   temperature                 shared temperature
//   temp_limit, power_min       alarm thresholds, sampled while reporting
//   out_valid/out_ready         record handshake
//   out_ch, out_last            record channel, last-channel flag
//   *_display                   averaged record fields
//   total_power_display         sum of averaged powers, valid with out_last
//   alarm, ot_alarm             under-power (per channel) / over-temperature
//   peak_power_display          peak averaged power of out_ch
//
// Optional feature macro: PEAK_HOLD_EN (per-channel peak hold of averaged
// power). Without it peak_power_display is tied to 0.
module multi_channel_solar_monitor #(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 12,
  parameter int AVG_LOG2  = 3,
  parameter int ALARM_CNT = 4,
  localparam int CH_W     = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic [N_CH*DATA_W-1:0]   voltage,
  input  logic [N_CH*DATA_W-1:0]   current,
  input  logic [DATA_W-1:0]        temperature,
  input  logic [DATA_W-1:0]        temp_limit,
  input  logic [DATA_W-1:0]        power_min,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_last,
  output logic [DATA_W-1:0]        voltage_display,
  output logic [DATA_W-1:0]        current_display,
  output logic [DATA_W-1:0]        power_display,
  output logic [DATA_W-1:0]        temperature_display,
  output logic [DATA_W+CH_W-1:0]   total_power_display,
  output logic [N_CH-1:0]          alarm,
  output logic                     ot_alarm,
  output logic [DATA_W-1:0]        peak_power_display
);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = $clog2(ALARM_CNT + 1);
  localparam int TOT_W = DATA_W + CH_W;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t                         state_q;
  logic [CH_W-1:0]                ch_q;
  logic [N_CH-1:0][DATA_W-1:0]    v_q, i_q;
  logic [DATA_W-1:0]              t_q;
  logic [N_CH-1:0][ACC_W-1:0]     accv_q, acci_q, accp_q;
  logic [ACC_W-1:0]               acct_q;
  logic [AVG_LOG2-1:0]            snap_q;
  logic [N_CH-1:0][CNT_W-1:0]     cnt_q;
  logic [N_CH-1:0]                alarm_q;
  logic                           ot_q, out_valid_q, out_last_q;
  logic [DATA_W-1:0]              vdisp_q, idisp_q, pdisp_q, tdisp_q;
  logic [TOT_W-1:0]               tot_q;

  // Shared multiplier; channel power is the truncated upper half.
  logic [2*DATA_W-1:0]            prod_d;
  logic [DATA_W-1:0]              pwr_d;
  assign prod_d = (2*DATA_W)'(v_q[ch_q]) * (2*DATA_W)'(i_q[ch_q]);
  assign pwr_d  = DATA_W'(prod_d >> DATA_W);

  // Window averages are plain right-shifts of the accumulators.
  logic [N_CH-1:0][DATA_W-1:0]    avg_v, avg_i, avg_p;
  logic [DATA_W-1:0]              avg_t;
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      avg_v[k] = accv_q[k][ACC_W-1:AVG_LOG2];
      avg_i[k] = acci_q[k][ACC_W-1:AVG_LOG2];
      avg_p[k] = accp_q[k][ACC_W-1:AVG_LOG2];
    end
    avg_t = acct_q[ACC_W-1:AVG_LOG2];
  end

  // A record is loaded when the window closes (ch 0) and on each non-last
  // accept (next channel).
  logic            ld_en;
  logic [CH_W-1:0] ld_ch;
  assign ld_en = (state_q == SCAN && ch_q == LAST_CH && (&snap_q)) ||
                 (state_q == REPORT && out_ready && !out_last_q);
  assign ld_ch = (state_q == REPORT) ? ch_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;     ch_q    <= '0;
      v_q     <= '0;       i_q     <= '0;  t_q    <= '0;
      accv_q  <= '0;       acci_q  <= '0;  accp_q <= '0;  acct_q <= '0;
      snap_q  <= '0;       cnt_q   <= '0;  alarm_q <= '0; ot_q <= 1'b0;
      out_valid_q <= 1'b0; out_last_q <= 1'b0;
      vdisp_q <= '0; idisp_q <= '0; pdisp_q <= '0; tdisp_q <= '0; tot_q <= '0;
    end else begin
      if (ld_en) begin
        vdisp_q <= avg_v[ld_ch];
        idisp_q <= avg_i[ld_ch];
        pdisp_q <= avg_p[ld_ch];
        tdisp_q <= avg_t;
        out_last_q <= (ld_ch == LAST_CH);
        tot_q <= (state_q == REPORT) ? tot_q + TOT_W'(avg_p[ld_ch]) : TOT_W'(avg_p[ld_ch]);
      end
      case (state_q)
        IDLE: if (sample_valid) begin
          v_q <= voltage; i_q <= current; t_q <= temperature;
          ch_q <= '0;
          state_q <= SCAN;
        end
        SCAN: begin
          accv_q[ch_q] <= accv_q[ch_q] + ACC_W'(v_q[ch_q]);
          acci_q[ch_q] <= acci_q[ch_q] + ACC_W'(i_q[ch_q]);
          accp_q[ch_q] <= accp_q[ch_q] + ACC_W'(pwr_d);
          if (ch_q == '0) acct_q <= acct_q + ACC_W'(t_q);
          if (ch_q == LAST_CH) begin
            snap_q <= snap_q + 1'b1;
            ch_q   <= '0;
            if (&snap_q) begin
              state_q     <= REPORT;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            ch_q <= ch_q + 1'b1;
          end
        end
        REPORT: if (out_ready) begin
          if (out_last_q) begin
            state_q <= IDLE; out_valid_q <= 1'b0; out_last_q <= 1'b0;
            ch_q <= '0;
            accv_q <= '0; acci_q <= '0; accp_q <= '0; acct_q <= '0;
            // Saturating low-power counters; any good window clears at once.
            for (int k = 0; k < N_CH; k++) begin
              if (avg_p[k] < power_min) begin
                alarm_q[k] <= (cnt_q[k] >= CNT_W'(ALARM_CNT - 1));
                if (cnt_q[k] < CNT_W'(ALARM_CNT)) cnt_q[k] <= cnt_q[k] + 1'b1;
              end else begin
                cnt_q[k]   <= '0;
                alarm_q[k] <= 1'b0;
              end
            end
            ot_q <= (avg_t > temp_limit);
          end else begin
            ch_q <= ch_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PEAK_HOLD_EN
  logic [N_CH-1:0][DATA_W-1:0] peak_q;
  logic [DATA_W-1:0]           pkdisp_q;
  // Peak is folded in as the record loads, so it is never below power_display.
  always_ff @(posedge clk) begin
    if (!reset) begin
      peak_q   <= '0;
      pkdisp_q <= '0;
    end else if (ld_en) begin
      if (avg_p[ld_ch] > peak_q[ld_ch]) begin
        peak_q[ld_ch] <= avg_p[ld_ch];
        pkdisp_q      <= avg_p[ld_ch];
      end else begin
        pkdisp_q <= peak_q[ld_ch];
      end
    end
  end
  assign peak_power_display = pkdisp_q;
`else
  assign peak_power_display = '0;
`endif

  assign sample_ready        = (state_q == IDLE);
  assign out_valid           = out_valid_q;
  assign out_ch              = ch_q;
  assign out_last            = out_last_q;
  assign voltage_display     = vdisp_q;
  assign current_display     = idisp_q;
  assign power_display       = pdisp_q;
  assign temperature_display = tdisp_q;
  assign total_power_display = tot_q;
  assign alarm               = alarm_q;
  assign ot_alarm            = ot_q;
endmodule

// File: tb/tb_multi_channel_solar_monitor.sv
// Self-checking bench for multi_channel_solar_monitor: directed windows plus
// randomized windows checked against a window-level arithmetic model.
module tb_multi_channel_solar_monitor;
  localparam int N_CH = 4;
  localparam int DW   = 12;
  localparam int AVG  = 3;
  localparam int NSNAP = 1 << AVG;
  localparam int ACNT = 4;

  typedef int arr_t [N_CH];

  logic clk = 1'b0;
  logic reset, sample_valid, sample_ready;
  logic [N_CH*DW-1:0] voltage, current;
  logic [DW-1:0] temperature, temp_limit, power_min;
  logic out_valid, out_ready, out_last, ot_alarm;
  logic [1:0] out_ch;
  logic [DW-1:0] voltage_display, current_display, power_display, temperature_display, peak_power_display;
  logic [DW+1:0] total_power_display;
  logic [N_CH-1:0] alarm;

  multi_channel_solar_monitor #(.N_CH(N_CH), .DATA_W(DW), .AVG_LOG2(AVG), .ALARM_CNT(ACNT)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .voltage(voltage), .current(current), .temperature(temperature),
    .temp_limit(temp_limit), .power_min(power_min),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_last(out_last),
    .voltage_display(voltage_display), .current_display(current_display),
    .power_display(power_display), .temperature_display(temperature_display),
    .total_power_display(total_power_display), .alarm(alarm), .ot_alarm(ot_alarm),
    .peak_power_display(peak_power_display));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Window model state
  int sv[N_CH], si[N_CH], sp[N_CH], st;
  int acnt[N_CH], peak_m[N_CH];
  logic [N_CH-1:0] am;
  logic ot_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear_window();
    for (int k = 0; k < N_CH; k++) begin sv[k] = 0; si[k] = 0; sp[k] = 0; end
    st = 0;
  endtask

  task automatic model_reset();
    model_clear_window();
    for (int k = 0; k < N_CH; k++) begin acnt[k] = 0; peak_m[k] = 0; end
    am = '0; ot_m = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_vld"},  out_valid, 0);
    chk({tag, "_ch"},   out_ch, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_v"},    voltage_display, 0);
    chk({tag, "_i"},    current_display, 0);
    chk({tag, "_p"},    power_display, 0);
    chk({tag, "_t"},    temperature_display, 0);
    chk({tag, "_tot"},  total_power_display, 0);
    chk({tag, "_alm"},  alarm, 0);
    chk({tag, "_ot"},   ot_alarm, 0);
    chk({tag, "_pk"},   peak_power_display, 0);
  endtask

  // Offer one snapshot, returns two negedges after acceptance (DUT mid-scan).
  task automatic send_snap(input arr_t v, input arr_t i, input int t);
    int b = 0;
    while (!sample_ready && b < 100) begin @(negedge clk); b++; end
    if (!sample_ready) begin chk("srdy_timeout", 0, 1); return; end
    for (int k = 0; k < N_CH; k++) begin
      voltage[k*DW +: DW] = DW'(v[k]);
      current[k*DW +: DW] = DW'(i[k]);
    end
    temperature  = DW'(t);
    sample_valid = 1'b1;
    @(negedge clk);
    // Occasionally offer junk while busy; it must be ignored.
    sample_valid = ($urandom_range(0, 1) == 1);
    voltage = {$urandom, $urandom};
    current = {$urandom, $urandom};
    @(negedge clk);
    sample_valid = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      sv[k] += v[k]; si[k] += i[k]; sp[k] += (v[k] * i[k]) >> DW;
    end
    st += t;
  endtask

  task automatic collect_window(input int stall_ch);
    int pa[N_CH];
    int ev, ei, ep, et, tot, n, b;
    logic [N_CH-1:0] ea;
    tot = 0;
    et = st >> AVG;
    for (int c = 0; c < N_CH; c++) begin
      b = 0;
      while (!out_valid && b < 50) begin @(negedge clk); b++; end
      if (!out_valid) begin chk("rec_timeout", 0, 1); return; end
      ev = sv[c] >> AVG; ei = si[c] >> AVG; ep = sp[c] >> AVG;
      pa[c] = ep; tot += ep;
      if (ep > peak_m[c]) peak_m[c] = ep;
      chk("rec_ch", out_ch, c);
      chk("rec_last", out_last, (c == N_CH-1));
      chk("rec_v", voltage_display, ev);
      chk("rec_i", current_display, ei);
      chk("rec_p", power_display, ep);
      chk("rec_t", temperature_display, et);
      chk("rec_srdy", sample_ready, 0);
      if (c == N_CH-1) chk("rec_total", total_power_display, tot);
`ifdef PEAK_HOLD_EN
      chk("rec_peak", peak_power_display, peak_m[c]);
`else
      chk("rec_peak0", peak_power_display, 0);
`endif
      n = (c == stall_ch) ? 5 : $urandom_range(0, 2);
      out_ready = 1'b0;
      repeat (n) begin
        @(negedge clk);
        chk("hold_vld", out_valid, 1);
        chk("hold_ch", out_ch, c);
        chk("hold_p", power_display, ep);
        chk("hold_srdy", sample_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    for (int k = 0; k < N_CH; k++) begin
      if (pa[k] < int'(power_min)) acnt[k] = (acnt[k] < ACNT) ? acnt[k] + 1 : ACNT;
      else acnt[k] = 0;
      ea[k] = (acnt[k] == ACNT);
    end
    am = ea;
    ot_m = (et > int'(temp_limit));
    model_clear_window();
    chk("win_vld", out_valid, 0);
    chk("win_alarm", alarm, am);
    chk("win_ot", ot_alarm, ot_m);
  endtask

  task automatic run_window(input arr_t v, input arr_t i, input int t, input int stall_ch);
    repeat (NSNAP) send_snap(v, i, t);
    collect_window(stall_ch);
  endtask

  task automatic run_rand_window();
    arr_t v, i;
    power_min  = DW'($urandom_range(0, 'h500));
    temp_limit = DW'($urandom_range(0, 'hFFF));
    repeat (NSNAP) begin
      for (int k = 0; k < N_CH; k++) begin
        v[k] = $urandom_range(0, 'hFFF);
        i[k] = $urandom_range(0, 'hFFF);
      end
      send_snap(v, i, $urandom_range(0, 'hFFF));
    end
    collect_window(int'($urandom_range(0, N_CH)));
  endtask

  initial begin
    arr_t v, i;
    reset = 1'b0; sample_valid = 1'b0; out_ready = 1'b0;
    voltage = '0; current = '0; temperature = '0;
    temp_limit = 12'hFFF; power_min = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("rst0");
    reset = 1'b1;
    @(negedge clk);
    chk("rst0_srdy", sample_ready, 1);

    // Uniform window: power 0x800*0x400>>12 = 0x200 per channel
    for (int k = 0; k < N_CH; k++) begin v[k] = 'h800; i[k] = 'h400; end
    run_window(v, i, 'h300, -1);
    chk("uni_total", total_power_display, 'h800);
    chk("uni_p3", power_display, 'h200);
    chk("uni_t", temperature_display, 'h300);

    // Half current, ch1 record stalled 5 cycles; peak must stay at 0x200
    for (int k = 0; k < N_CH; k++) i[k] = 'h200;
    run_window(v, i, 'h300, 1);
    chk("half_p3", power_display, 'h100);
`ifdef PEAK_HOLD_EN
    chk("half_peak", peak_power_display, 'h200);
`else
    chk("half_peak0", peak_power_display, 0);
`endif

    // Under-power on ch2 for four windows, then recovery
    power_min = 12'h100;
    for (int k = 0; k < N_CH; k++) i[k] = 'h400;
    i[2] = 0;
    for (int w = 1; w <= 4; w++) begin
      run_window(v, i, 'h300, -1);
      chk("lowp_alarm2", alarm[2], (w == 4));
      chk("lowp_others", alarm & 4'b1011, 0);
    end
    i[2] = 'h400;
    run_window(v, i, 'h300, -1);
    chk("lowp_clear", alarm, 0);

    // Over-temperature then recovery
    temp_limit = 12'h900;
    run_window(v, i, 'hA00, -1);
    chk("ot_set", ot_alarm, 1);
    run_window(v, i, 'h800, -1);
    chk("ot_clr", ot_alarm, 0);

    repeat (6) run_rand_window();

    // Reset in the middle of a scan discards the partial window
    for (int k = 0; k < N_CH; k++) begin v[k] = 'h800; i[k] = 'h400; end
    send_snap(v, i, 'h300);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("rst1");
    model_reset();
    reset = 1'b1;
    @(negedge clk);
    chk("rst1_srdy", sample_ready, 1);
    power_min = 12'h000; temp_limit = 12'hFFF;
    run_window(v, i, 'h300, -1);
    chk("fresh_total", total_power_display, 'h800);
    chk("fresh_v", voltage_display, 'h800);
    repeat (2) run_rand_window();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so a stuck handshake cannot hang the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
